rs_scheduler: RTL and testbench

Reservation station and dispatch scheduler between the decoder issue port and the ALU. It buffers issued instructions whose operands may still depend on ROB entries. It snoops the two result buses (ALU and LSB) to wake up waiting operands. Each cycle it selects one operand-ready entry and dispatches it to the ALU.

---
 rtl/rs_scheduler_if.sv | 48 ++++
 rtl/rs_scheduler.sv | 151 +++++++++++++++
 tb/tb_rs_scheduler.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/rs_scheduler_if.sv
// Decoder issue port, both result broadcasts and the ALU dispatch port of the reservation station.
// The decoder/CDB side drives through master; the scheduler consumes through slave.
interface rs_scheduler_if #(
    parameter int ROB_W = 4,
    parameter int OP_W  = 6
);
    logic             issue_ready;
    logic [OP_W-1:0]  issue_op;
    logic [31:0]      issue_rs1_val;
    logic [31:0]      issue_rs2_val;
    logic [ROB_W-1:0] issue_rs1_depend;
    logic [ROB_W-1:0] issue_rs2_depend;
    logic [31:0]      issue_imm;
    logic [31:0]      issue_PC;
    logic [ROB_W-1:0] issue_rob_index;
    logic             rs_full;

    logic             alu_cdb_valid;
    logic [ROB_W-1:0] alu_cdb_rob_index;
    logic [31:0]      alu_cdb_val;
    logic             lsb_cdb_valid;
    logic [ROB_W-1:0] lsb_cdb_rob_index;
    logic [31:0]      lsb_cdb_val;

    logic             alu_valid;
    logic [OP_W-1:0]  alu_op;
    logic [31:0]      alu_rs1;
    logic [31:0]      alu_rs2;
    logic [31:0]      alu_imm;
    logic [31:0]      alu_PC;
    logic [ROB_W-1:0] alu_rob_index;

    modport master (
        output issue_ready, issue_op, issue_rs1_val, issue_rs2_val,
               issue_rs1_depend, issue_rs2_depend, issue_imm, issue_PC, issue_rob_index,
               alu_cdb_valid, alu_cdb_rob_index, alu_cdb_val,
               lsb_cdb_valid, lsb_cdb_rob_index, lsb_cdb_val,
        input  rs_full, alu_valid, alu_op, alu_rs1, alu_rs2, alu_imm, alu_PC, alu_rob_index
    );

    modport slave (
        input  issue_ready, issue_op, issue_rs1_val, issue_rs2_val,
               issue_rs1_depend, issue_rs2_depend, issue_imm, issue_PC, issue_rob_index,
               alu_cdb_valid, alu_cdb_rob_index, alu_cdb_val,
               lsb_cdb_valid, lsb_cdb_rob_index, lsb_cdb_val,
        output rs_full, alu_valid, alu_op, alu_rs1, alu_rs2, alu_imm, alu_PC, alu_rob_index
    );
endinterface

// File: rtl/rs_scheduler.sv
// Reservation station: buffers issued ops, snoops ALU/LSB CDBs, dispatches lowest ready entry.
// Latency: ready-at-issue op dispatches on the second edge; wake-up to dispatch is one edge.
// Backpressure: rs_full from registered state; issues while full are dropped, rdy_in low freezes all.
module rs_scheduler #(
    parameter int RS_SIZE = 8,
    parameter int ROB_W   = 4,
    parameter int OP_W    = 6
) (
    input  logic          clk_in,
    input  logic          rst_n_in,
    input  logic          rdy_in,
    input  logic          clear_in,
    rs_scheduler_if.slave bus
);
    localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

    typedef struct packed {
        logic [OP_W-1:0]  op;
        logic [31:0]      v1;
        logic [ROB_W-1:0] q1;
        logic [31:0]      v2;
        logic [ROB_W-1:0] q2;
        logic [31:0]      imm;
        logic [31:0]      pc;
        logic [ROB_W-1:0] rob;
    } entry_t;

    typedef struct packed {
        logic [OP_W-1:0]  op;
        logic [31:0]      rs1;
        logic [31:0]      rs2;
        logic [31:0]      imm;
        logic [31:0]      pc;
        logic [ROB_W-1:0] rob;
    } out_t;

    typedef struct packed {
        logic [ROB_W-1:0] q;
        logic [31:0]      v;
    } opnd_t;

    entry_t             ent_q [RS_SIZE];
    entry_t             ent_d [RS_SIZE];
    logic [RS_SIZE-1:0] busy_q, busy_d;
    out_t               out_q, out_d;
    logic               alu_valid_q, alu_valid_d;

    logic [IDX_W-1:0]   free_idx, sel_idx;
    logic               sel_vld;
    logic               full;

    // ALU broadcast takes priority when both buses carry the awaited index.
    function automatic opnd_t snoop(input opnd_t cur,
                                    input logic av, input logic [ROB_W-1:0] ai, input logic [31:0] ad,
                                    input logic lv, input logic [ROB_W-1:0] li, input logic [31:0] ld);
        snoop = cur;
        if (cur.q != '0) begin
            if (av && cur.q == ai)      snoop = '{q: '0, v: ad};
            else if (lv && cur.q == li) snoop = '{q: '0, v: ld};
        end
    endfunction

    assign full = &busy_q;

    always_comb begin
        free_idx = '0;
        sel_idx  = '0;
        sel_vld  = 1'b0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!busy_q[i]) free_idx = IDX_W'(i);
            if (busy_q[i] && ent_q[i].q1 == '0 && ent_q[i].q2 == '0) begin
                sel_idx = IDX_W'(i);
                sel_vld = 1'b1;
            end
        end
    end

    always_comb begin
        opnd_t o1, o2;
        o1          = '0;
        o2          = '0;
        busy_d      = busy_q;
        ent_d       = ent_q;
        out_d       = out_q;
        alu_valid_d = 1'b0;

        for (int i = 0; i < RS_SIZE; i++) begin
            if (busy_q[i]) begin
                o1 = snoop('{q: ent_q[i].q1, v: ent_q[i].v1},
                           bus.alu_cdb_valid, bus.alu_cdb_rob_index, bus.alu_cdb_val,
                           bus.lsb_cdb_valid, bus.lsb_cdb_rob_index, bus.lsb_cdb_val);
                o2 = snoop('{q: ent_q[i].q2, v: ent_q[i].v2},
                           bus.alu_cdb_valid, bus.alu_cdb_rob_index, bus.alu_cdb_val,
                           bus.lsb_cdb_valid, bus.lsb_cdb_rob_index, bus.lsb_cdb_val);
                ent_d[i].q1 = o1.q;
                ent_d[i].v1 = o1.v;
                ent_d[i].q2 = o2.q;
                ent_d[i].v2 = o2.v;
            end
        end

        if (sel_vld) begin
            busy_d[sel_idx] = 1'b0;
            alu_valid_d     = 1'b1;
            out_d = '{op: ent_q[sel_idx].op, rs1: ent_q[sel_idx].v1, rs2: ent_q[sel_idx].v2,
                      imm: ent_q[sel_idx].imm, pc: ent_q[sel_idx].pc, rob: ent_q[sel_idx].rob};
        end

        // The free slot comes from pre-edge state, so a slot freed by dispatch is never reused this edge.
        if (bus.issue_ready && !full) begin
            o1 = snoop('{q: bus.issue_rs1_depend, v: bus.issue_rs1_val},
                       bus.alu_cdb_valid, bus.alu_cdb_rob_index, bus.alu_cdb_val,
                       bus.lsb_cdb_valid, bus.lsb_cdb_rob_index, bus.lsb_cdb_val);
            o2 = snoop('{q: bus.issue_rs2_depend, v: bus.issue_rs2_val},
                       bus.alu_cdb_valid, bus.alu_cdb_rob_index, bus.alu_cdb_val,
                       bus.lsb_cdb_valid, bus.lsb_cdb_rob_index, bus.lsb_cdb_val);
            ent_d[free_idx]  = '{op: bus.issue_op, v1: o1.v, q1: o1.q, v2: o2.v, q2: o2.q,
                                 imm: bus.issue_imm, pc: bus.issue_PC, rob: bus.issue_rob_index};
            busy_d[free_idx] = 1'b1;
        end

        if (clear_in) begin
            busy_d      = '0;
            alu_valid_d = 1'b0;
            out_d       = out_q;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            busy_q      <= '0;
            out_q       <= '0;
            alu_valid_q <= 1'b0;
            for (int i = 0; i < RS_SIZE; i++) ent_q[i] <= '0;
        end else if (rdy_in) begin
            busy_q      <= busy_d;
            out_q       <= out_d;
            alu_valid_q <= alu_valid_d;
            for (int i = 0; i < RS_SIZE; i++) ent_q[i] <= ent_d[i];
        end
    end

    assign bus.rs_full       = full;
    assign bus.alu_valid     = alu_valid_q;
    assign bus.alu_op        = out_q.op;
    assign bus.alu_rs1       = out_q.rs1;
    assign bus.alu_rs2       = out_q.rs2;
    assign bus.alu_imm       = out_q.imm;
    assign bus.alu_PC        = out_q.pc;
    assign bus.alu_rob_index = out_q.rob;
endmodule

// File: tb/tb_rs_scheduler.sv
// Bench for rs_scheduler: directed scenarios plus random traffic against an entry-list model.
// Inputs change on the falling edge; the model steps on the rising edge; outputs compare on the falling edge.
module tb_rs_scheduler;
    logic clk = 1'b0;
    logic rst_n;
    logic rdy;
    logic clear;
    int   n_chk  = 0;
    int   n_fail = 0;

    rs_scheduler_if #(.ROB_W(4), .OP_W(6)) bus ();

    rs_scheduler #(.RS_SIZE(8), .ROB_W(4), .OP_W(6)) dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .rdy_in   (rdy),
        .clear_in (clear),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          busy;
        logic [5:0]  op;
        logic [31:0] v1, v2, imm, pc;
        logic [3:0]  q1, q2, rob;
    } ment_t;

    ment_t       m [8];
    logic        e_valid;
    logic [5:0]  e_op;
    logic [31:0] e_rs1, e_rs2, e_imm, e_pc;
    logic [3:0]  e_rob;

    function automatic bit m_full();
        for (int i = 0; i < 8; i++) if (!m[i].busy) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit cdb_hit(input logic [3:0] q, output logic [31:0] v);
        v = '0;
        if (q == 4'd0) return 1'b0;
        if (bus.alu_cdb_valid && q == bus.alu_cdb_rob_index) begin v = bus.alu_cdb_val; return 1'b1; end
        if (bus.lsb_cdb_valid && q == bus.lsb_cdb_rob_index) begin v = bus.lsb_cdb_val; return 1'b1; end
        return 1'b0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m[i] = '{default: '0};
        e_valid = 1'b0; e_op = '0; e_rs1 = '0; e_rs2 = '0; e_imm = '0; e_pc = '0; e_rob = '0;
    endtask

    task automatic model_step();
        int pick, slot;
        bit was_full;
        logic [31:0] t;
        if (!rdy) return;
        if (clear) begin
            for (int i = 0; i < 8; i++) m[i].busy = 1'b0;
            e_valid = 1'b0;
            return;
        end
        was_full = m_full();
        pick = -1;
        slot = -1;
        for (int i = 0; i < 8; i++) begin
            if (pick < 0 && m[i].busy && m[i].q1 == 0 && m[i].q2 == 0) pick = i;
            if (slot < 0 && !m[i].busy) slot = i;
        end
        e_valid = (pick >= 0);
        if (pick >= 0) begin
            e_op = m[pick].op; e_rs1 = m[pick].v1; e_rs2 = m[pick].v2;
            e_imm = m[pick].imm; e_pc = m[pick].pc; e_rob = m[pick].rob;
            m[pick].busy = 1'b0;
        end
        for (int i = 0; i < 8; i++) begin
            if (m[i].busy) begin
                if (cdb_hit(m[i].q1, t)) begin m[i].v1 = t; m[i].q1 = 0; end
                if (cdb_hit(m[i].q2, t)) begin m[i].v2 = t; m[i].q2 = 0; end
            end
        end
        if (bus.issue_ready && !was_full) begin
            m[slot] = '{busy: 1'b1, op: bus.issue_op, v1: bus.issue_rs1_val, v2: bus.issue_rs2_val,
                        imm: bus.issue_imm, pc: bus.issue_PC, q1: bus.issue_rs1_depend,
                        q2: bus.issue_rs2_depend, rob: bus.issue_rob_index};
            if (cdb_hit(m[slot].q1, t)) begin m[slot].v1 = t; m[slot].q1 = 0; end
            if (cdb_hit(m[slot].q2, t)) begin m[slot].v2 = t; m[slot].q2 = 0; end
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else        model_step();
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("alu_valid", 64'(bus.alu_valid), 64'(e_valid));
        chk("rs_full", 64'(bus.rs_full), 64'(m_full()));
        chk("alu_op", 64'(bus.alu_op), 64'(e_op));
        chk("alu_rs1", 64'(bus.alu_rs1), 64'(e_rs1));
        chk("alu_rs2", 64'(bus.alu_rs2), 64'(e_rs2));
        chk("alu_imm", 64'(bus.alu_imm), 64'(e_imm));
        chk("alu_PC", 64'(bus.alu_PC), 64'(e_pc));
        chk("alu_rob_index", 64'(bus.alu_rob_index), 64'(e_rob));
    end

    task automatic idle();
        bus.issue_ready = 1'b0; bus.issue_op = '0; bus.issue_rs1_val = '0; bus.issue_rs2_val = '0;
        bus.issue_rs1_depend = '0; bus.issue_rs2_depend = '0; bus.issue_imm = '0; bus.issue_PC = '0;
        bus.issue_rob_index = 4'd1;
        bus.alu_cdb_valid = 1'b0; bus.alu_cdb_rob_index = '0; bus.alu_cdb_val = '0;
        bus.lsb_cdb_valid = 1'b0; bus.lsb_cdb_rob_index = '0; bus.lsb_cdb_val = '0;
        rdy = 1'b1; clear = 1'b0;
    endtask

    task automatic issue(input logic [5:0] op, input logic [31:0] v1, input logic [3:0] d1,
                         input logic [31:0] v2, input logic [3:0] d2, input logic [3:0] rob);
        bus.issue_ready = 1'b1; bus.issue_op = op;
        bus.issue_rs1_val = v1; bus.issue_rs1_depend = d1;
        bus.issue_rs2_val = v2; bus.issue_rs2_depend = d2;
        bus.issue_imm = {28'h0, rob} + 32'h100; bus.issue_PC = {26'h0, op} << 2;
        bus.issue_rob_index = rob;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        step(); step();
        chk("reset alu_valid", 64'(bus.alu_valid), 64'd0);
        chk("reset rs_full", 64'(bus.rs_full), 64'd0);
        chk("reset alu_rs1", 64'(bus.alu_rs1), 64'd0);
        rst_n = 1'b1;
        step();

        // 1: ready-at-issue op dispatches two edges later for exactly one cycle
        issue(6'd1, 32'd5, 4'd0, 32'd7, 4'd0, 4'd3);
        step(); idle();
        chk("t1 no early dispatch", 64'(bus.alu_valid), 64'd0);
        step();
        chk("t1 alu_valid", 64'(bus.alu_valid), 64'd1);
        chk("t1 alu_rs1", 64'(bus.alu_rs1), 64'd5);
        chk("t1 alu_rs2", 64'(bus.alu_rs2), 64'd7);
        chk("t1 alu_rob_index", 64'(bus.alu_rob_index), 64'd3);
        step();
        chk("t1 single pulse", 64'(bus.alu_valid), 64'd0);

        // 2: waiting on ROB 2, woken by the ALU CDB
        issue(6'd2, 32'hFFFF, 4'd2, 32'd9, 4'd0, 4'd4);
        step(); idle();
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t2 waits", 64'(bus.alu_valid), 64'd0);
        end
        bus.alu_cdb_valid = 1'b1; bus.alu_cdb_rob_index = 4'd2; bus.alu_cdb_val = 32'h1234;
        step(); idle();
        chk("t2 wake edge no dispatch", 64'(bus.alu_valid), 64'd0);
        step();
        chk("t2 alu_valid", 64'(bus.alu_valid), 64'd1);
        chk("t2 alu_rs1", 64'(bus.alu_rs1), 64'h1234);
        step();

        // 3: same-cycle bypass from LSB, then ALU priority when both match
        issue(6'd3, 32'd1, 4'd0, 32'd0, 4'd5, 4'd6);
        bus.lsb_cdb_valid = 1'b1; bus.lsb_cdb_rob_index = 4'd5; bus.lsb_cdb_val = 32'hDEAD;
        step(); idle();
        step();
        chk("t3 lsb bypass valid", 64'(bus.alu_valid), 64'd1);
        chk("t3 lsb bypass rs2", 64'(bus.alu_rs2), 64'hDEAD);
        issue(6'd3, 32'd1, 4'd0, 32'd0, 4'd5, 4'd7);
        bus.lsb_cdb_valid = 1'b1; bus.lsb_cdb_rob_index = 4'd5; bus.lsb_cdb_val = 32'hDEAD;
        bus.alu_cdb_valid = 1'b1; bus.alu_cdb_rob_index = 4'd5; bus.alu_cdb_val = 32'hBEEF;
        step(); idle();
        step();
        chk("t3 alu priority rs2", 64'(bus.alu_rs2), 64'hBEEF);
        step();

        // 4: fill, drop a 9th issue, release all, in-order dispatch
        for (int i = 0; i < 8; i++) begin
            issue(6'd4, 32'd0, 4'd1, 32'd0, 4'd1, 4'(i + 3));
            step();
        end
        chk("t4 rs_full", 64'(bus.rs_full), 64'd1);
        issue(6'd5, 32'd0, 4'd0, 32'd0, 4'd0, 4'd15);
        step(); idle();
        chk("t4 still full", 64'(bus.rs_full), 64'd1);
        bus.alu_cdb_valid = 1'b1; bus.alu_cdb_rob_index = 4'd1; bus.alu_cdb_val = 32'h100;
        step(); idle();
        for (int k = 0; k < 8; k++) begin
            step();
            chk("t4 dispatch valid", 64'(bus.alu_valid), 64'd1);
            chk("t4 dispatch order", 64'(bus.alu_rob_index), 64'(k + 3));
            if (k == 0) chk("t4 full drops", 64'(bus.rs_full), 64'd0);
        end
        step();
        chk("t4 dropped 9th never runs", 64'(bus.alu_valid), 64'd0);

        // 5: flush with simultaneous issue
        for (int i = 0; i < 4; i++) begin
            issue(6'd6, 32'd0, 4'd6, 32'd0, 4'd0, 4'(i + 1));
            step();
        end
        issue(6'd7, 32'd2, 4'd0, 32'd3, 4'd0, 4'd9);
        clear = 1'b1;
        step(); idle();
        chk("t5 flushed", 64'(bus.rs_full), 64'd0);
        chk("t5 alu_valid", 64'(bus.alu_valid), 64'd0);
        bus.alu_cdb_valid = 1'b1; bus.alu_cdb_rob_index = 4'd6; bus.alu_cdb_val = 32'h66;
        step(); idle();
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t5 no dispatch after flush", 64'(bus.alu_valid), 64'd0);
        end

        // 6: freeze with rdy low, then async reset mid-cycle
        issue(6'd8, 32'd0, 4'd7, 32'd4, 4'd0, 4'd9);
        step(); idle();
        rdy = 1'b0; clear = 1'b1; bus.issue_ready = 1'b1;
        bus.alu_cdb_valid = 1'b1; bus.alu_cdb_rob_index = 4'd7; bus.alu_cdb_val = 32'h77;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t6 frozen", 64'(bus.alu_valid), 64'd0);
        end
        idle();
        for (int i = 0; i < 2; i++) begin
            step();
            chk("t6 no wake while frozen", 64'(bus.alu_valid), 64'd0);
        end
        bus.alu_cdb_valid = 1'b1; bus.alu_cdb_rob_index = 4'd7; bus.alu_cdb_val = 32'h77;
        step(); idle();
        step();
        chk("t6 dispatch after thaw", 64'(bus.alu_valid), 64'd1);
        chk("t6 rs1", 64'(bus.alu_rs1), 64'h77);
        #2 rst_n = 1'b0;
        #1 chk("t6 async reset", 64'(bus.alu_valid), 64'd0);
        step();
        rst_n = 1'b1;

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            idle();
            rdy   = ($urandom % 10) != 0;
            clear = ($urandom % 80) == 0;
            if ((!m_full() && ($urandom % 3) != 0) || ($urandom % 50) == 0)
                issue(6'($urandom), $urandom,
                      ($urandom % 2) ? 4'd0 : 4'($urandom_range(1, 7)), $urandom,
                      ($urandom % 2) ? 4'd0 : 4'($urandom_range(1, 7)), 4'($urandom_range(1, 15)));
            bus.issue_imm = $urandom;
            bus.issue_PC  = $urandom;
            if ($urandom % 2) begin
                bus.alu_cdb_valid = 1'b1; bus.alu_cdb_rob_index = 4'($urandom_range(1, 7));
                bus.alu_cdb_val = $urandom;
            end
            if ($urandom % 2) begin
                bus.lsb_cdb_valid = 1'b1; bus.lsb_cdb_rob_index = 4'($urandom_range(1, 7));
                bus.lsb_cdb_val = $urandom;
            end
            step();
        end
        idle();
        step(); step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
